// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one backing memory port between the fetch
// read channel and the load/store channels. Holds exactly one transaction
// outstanding and routes the completion back to the requester that owns it.
module mem_port_arbiter #(
    parameter int IDX_W    = 64,
    parameter int DATA_W   = 64,
    parameter int LSU_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    // fetch channel
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [IDX_W-1:0]  if_req_index,
    input  logic              if_kill,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    // load channel
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [IDX_W-1:0]  ld_req_index,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_rdata,
    // store channel
    input  logic              st_req_valid,
    output logic              st_req_ready,
    input  logic [IDX_W-1:0]  st_req_index,
    input  logic [DATA_W-1:0] st_wdata,
    input  logic [63:0]       st_wmask,
    output logic              st_done,
    // memory port
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [IDX_W-1:0]  mem_req_index,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [63:0]       mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic [1:0] {OWN_IF, OWN_LD, OWN_ST} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                kill_q, kill_d;          // fetch response must be swallowed
    logic                last_lsu_q, last_lsu_d;  // 1 = LSU won the previous grant
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [63:0]         wmask_q, wmask_d;

    logic if_cand, lsu_cand, pick_if, resp_fire;

    // State register; reset drops any transaction in flight.
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_IF;
            kill_q     <= 1'b0;
            last_lsu_q <= 1'b1;
            idx_q      <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            kill_q     <= kill_d;
            last_lsu_q <= last_lsu_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
        end
    end

    // Arbitration, next-state and all port/completion outputs.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        kill_d        = kill_q;
        last_lsu_d    = last_lsu_q;
        idx_d         = idx_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        if_req_ready  = 1'b0;
        ld_req_ready  = 1'b0;
        st_req_ready  = 1'b0;
        if_done       = 1'b0;
        ld_done       = 1'b0;
        st_done       = 1'b0;
        if_rdata      = '0;
        ld_rdata      = '0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_index = '0;
        mem_req_wdata = '0;
        mem_req_wmask = '0;

        // A killed fetch is never eligible; store always outranks load.
        if_cand  = if_req_valid && !if_kill;
        lsu_cand = ld_req_valid || st_req_valid;
        if (if_cand && lsu_cand) begin
            pick_if = (LSU_PRIO == 0) && last_lsu_q;
        end else begin
            pick_if = if_cand;
        end
        resp_fire = 1'b0;

        if (!reset) begin
            unique case (state_q)
                S_IDLE: begin
                    if (pick_if) begin
                        if_req_ready = 1'b1;
                        owner_d      = OWN_IF;
                        idx_d        = if_req_index;
                        wdata_d      = '0;
                        wmask_d      = '0;
                    end else if (st_req_valid) begin
                        st_req_ready = 1'b1;
                        owner_d      = OWN_ST;
                        idx_d        = st_req_index;
                        wdata_d      = st_wdata;
                        wmask_d      = st_wmask;
                    end else if (ld_req_valid) begin
                        ld_req_ready = 1'b1;
                        owner_d      = OWN_LD;
                        idx_d        = ld_req_index;
                        wdata_d      = '0;
                        wmask_d      = '0;
                    end
                    if (pick_if || lsu_cand) begin
                        state_d    = S_ISSUE;
                        kill_d     = 1'b0;
                        last_lsu_d = !pick_if;
                    end
                end
                S_ISSUE: begin
                    mem_req_valid = 1'b1;
                    mem_req_write = (owner_q == OWN_ST);
                    mem_req_index = idx_q;
                    mem_req_wdata = wdata_q;
                    mem_req_wmask = wmask_q;
                    if (owner_q == OWN_IF && if_kill) kill_d = 1'b1;
                    if (mem_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (owner_q == OWN_IF && if_kill) kill_d = 1'b1;
                    resp_fire = mem_resp_valid;
                    if (resp_fire) begin
                        state_d = S_IDLE;
                        kill_d  = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Completion routing; a fetch killed now or earlier gets no pulse.
        if (resp_fire) begin
            unique case (owner_q)
                OWN_IF: begin
                    if (!kill_q && !if_kill) begin
                        if_done  = 1'b1;
                        if_rdata = mem_resp_rdata;
                    end
                end
                OWN_LD: begin
                    ld_done  = 1'b1;
                    ld_rdata = mem_resp_rdata;
                end
                OWN_ST: st_done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model checked every cycle
// against the round-robin instance, directed scenarios with literal expectations,
// and a fixed-priority instance exercised by the fetch/load contention scenario.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 0, if_kill = 0, ld_req_valid = 0, st_req_valid = 0;
    logic [63:0] if_req_index = 0, ld_req_index = 0, st_req_index = 0;
    logic [63:0] st_wdata = 0, st_wmask = 0, mem_resp_rdata = 0;
    logic        mem_req_ready = 0, mem_resp_valid = 0;

    logic        if_req_ready, if_done, ld_req_ready, ld_done, st_req_ready, st_done;
    logic        mem_req_valid, mem_req_write;
    logic [63:0] if_rdata, ld_rdata, mem_req_index, mem_req_wdata, mem_req_wmask;

    logic        p_if_req_ready, p_if_done, p_ld_req_ready, p_ld_done, p_st_req_ready, p_st_done;
    logic        p_mem_req_valid, p_mem_req_write;
    logic [63:0] p_if_rdata, p_ld_rdata, p_mem_req_index, p_mem_req_wdata, p_mem_req_wmask;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.IDX_W(64), .DATA_W(64), .LSU_PRIO(0)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_index(if_req_index),
        .if_kill(if_kill), .if_done(if_done), .if_rdata(if_rdata),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_index(ld_req_index),
        .ld_done(ld_done), .ld_rdata(ld_rdata),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_index(st_req_index),
        .st_wdata(st_wdata), .st_wmask(st_wmask), .st_done(st_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_req_index(mem_req_index), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    mem_port_arbiter #(.IDX_W(64), .DATA_W(64), .LSU_PRIO(1)) dut_p (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(p_if_req_ready), .if_req_index(if_req_index),
        .if_kill(if_kill), .if_done(p_if_done), .if_rdata(p_if_rdata),
        .ld_req_valid(ld_req_valid), .ld_req_ready(p_ld_req_ready), .ld_req_index(ld_req_index),
        .ld_done(p_ld_done), .ld_rdata(p_ld_rdata),
        .st_req_valid(st_req_valid), .st_req_ready(p_st_req_ready), .st_req_index(st_req_index),
        .st_wdata(st_wdata), .st_wmask(st_wmask), .st_done(p_st_done),
        .mem_req_valid(p_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(p_mem_req_write),
        .mem_req_index(p_mem_req_index), .mem_req_wdata(p_mem_req_wdata), .mem_req_wmask(p_mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // ---------------- transaction-level model of the round-robin instance ----------------
    localparam int WHO_IF = 0, WHO_LD = 1, WHO_ST = 2;
    bit          m_busy = 0;       // a transaction has been accepted and not completed
    bit          m_sent = 0;       // that transaction has been taken by the port
    int          m_who = 0;
    logic [63:0] m_idx = 0, m_wdata = 0, m_wmask = 0;
    bit          m_killed = 0;
    bit          m_fetch_last = 0; // previous grant went to fetch

    always @(negedge clock) begin : compare
        logic e_ifr, e_ldr, e_str, e_ifd, e_ldd, e_std, e_mv, e_mw;
        logic [63:0] e_ifdat, e_lddat, e_midx, e_mwd, e_mwm;
        bit f, s, l;
        int who;
        e_ifr = 0; e_ldr = 0; e_str = 0; e_ifd = 0; e_ldd = 0; e_std = 0; e_mv = 0; e_mw = 0;
        e_ifdat = 0; e_lddat = 0; e_midx = 0; e_mwd = 0; e_mwm = 0;
        who = -1;

        if (reset) begin
            m_busy = 0; m_sent = 0; m_killed = 0; m_fetch_last = 0;
        end else if (!m_busy) begin
            f = if_req_valid && !if_kill;
            s = st_req_valid;
            l = ld_req_valid;
            if (f && (s || l)) who = m_fetch_last ? (s ? WHO_ST : WHO_LD) : WHO_IF;
            else if (f) who = WHO_IF;
            else if (s) who = WHO_ST;
            else if (l) who = WHO_LD;
            if (who >= 0) begin
                e_ifr = (who == WHO_IF); e_ldr = (who == WHO_LD); e_str = (who == WHO_ST);
                m_busy = 1; m_sent = 0; m_killed = 0; m_who = who;
                m_fetch_last = (who == WHO_IF);
                m_idx   = (who == WHO_IF) ? if_req_index : (who == WHO_LD) ? ld_req_index : st_req_index;
                m_wdata = (who == WHO_ST) ? st_wdata : 64'd0;
                m_wmask = (who == WHO_ST) ? st_wmask : 64'd0;
            end
        end else if (!m_sent) begin
            e_mv = 1; e_mw = (m_who == WHO_ST);
            e_midx = m_idx; e_mwd = m_wdata; e_mwm = m_wmask;
            if (m_who == WHO_IF && if_kill) m_killed = 1;
            if (mem_req_ready) m_sent = 1;
        end else begin
            if (m_who == WHO_IF && if_kill) m_killed = 1;
            if (mem_resp_valid) begin
                if (m_who == WHO_IF && !m_killed) begin e_ifd = 1; e_ifdat = mem_resp_rdata; end
                if (m_who == WHO_LD) begin e_ldd = 1; e_lddat = mem_resp_rdata; end
                if (m_who == WHO_ST) e_std = 1;
                m_busy = 0; m_sent = 0; m_killed = 0;
            end
        end

        check("if_req_ready", if_req_ready, e_ifr);
        check("ld_req_ready", ld_req_ready, e_ldr);
        check("st_req_ready", st_req_ready, e_str);
        check("if_done", if_done, e_ifd);
        check("ld_done", ld_done, e_ldd);
        check("st_done", st_done, e_std);
        check("if_rdata", if_rdata, e_ifdat);
        check("ld_rdata", ld_rdata, e_lddat);
        check("mem_req_valid", mem_req_valid, e_mv);
        check("mem_req_write", mem_req_write, e_mw);
        check("mem_req_index", mem_req_index, e_midx);
        check("mem_req_wdata", mem_req_wdata, e_mwd);
        check("mem_req_wmask", mem_req_wmask, e_mwm);
    end

    // Watchdog: the directed sequence is fixed-length, this only guards a broken bench.
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed scenarios with literal expectations ----------------
    initial begin
        byte grants[$];
        int  p_if_grants, p_ld_grants;

        // reset: all outputs idle
        cyc();
        @(negedge clock);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_ld_done", ld_done, 0);
        cyc();
        reset = 0;

        // single load, port ready at once, response three cycles on
        ld_req_valid = 1; ld_req_index = 64'h10; mem_req_ready = 1;
        @(negedge clock); check("ld1_ready", ld_req_ready, 1);
        cyc(); ld_req_valid = 0;
        @(negedge clock); check("ld1_port_idx", mem_req_index, 64'h10);
        cyc(); cyc(); cyc();
        mem_resp_valid = 1; mem_resp_rdata = 64'hDEAD;
        @(negedge clock);
        check("ld1_done", ld_done, 1);
        check("ld1_rdata", ld_rdata, 64'hDEAD);
        cyc(); mem_resp_valid = 0; mem_resp_rdata = 0;
        @(negedge clock); check("ld1_done_pulse", ld_done, 0);

        // store with the port stalled for four cycles
        cyc();
        mem_req_ready = 0;
        st_req_valid = 1; st_req_index = 64'h20; st_wdata = 64'hFF00; st_wmask = 64'hFF00;
        @(negedge clock); check("st1_ready", st_req_ready, 1);
        cyc(); st_req_valid = 0; st_wdata = 0; st_wmask = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("st1_hold_valid", mem_req_valid, 1);
            check("st1_hold_idx", mem_req_index, 64'h20);
            check("st1_hold_wdata", mem_req_wdata, 64'hFF00);
            check("st1_hold_wmask", mem_req_wmask, 64'hFF00);
            check("st1_hold_write", mem_req_write, 1);
            cyc();
        end
        mem_req_ready = 1;
        cyc();
        mem_resp_valid = 1;
        @(negedge clock); check("st1_done", st_done, 1);
        cyc(); mem_resp_valid = 0;

        // fetch and load contending every cycle; port always ready and answering
        if_req_valid = 1; if_req_index = 64'h100;
        ld_req_valid = 1; ld_req_index = 64'h18;
        mem_resp_valid = 1; mem_resp_rdata = 64'h55;
        p_if_grants = 0; p_ld_grants = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (if_req_ready) grants.push_back("F");
            if (ld_req_ready) grants.push_back("L");
            if (p_if_req_ready) p_if_grants++;
            if (p_ld_req_ready) p_ld_grants++;
            cyc();
        end
        if_req_valid = 0; ld_req_valid = 0;
        repeat (3) cyc();
        mem_resp_valid = 0; mem_resp_rdata = 0;
        check("rr_grant_count", grants.size(), 4);
        if (grants.size() >= 3) begin
            check("rr_grant0", grants[0], "F");
            check("rr_grant1", grants[1], "L");
            check("rr_grant2", grants[2], "F");
        end
        check("prio_fetch_grants", p_if_grants, 0);
        check("prio_load_grants", p_ld_grants, 4);

        // load and store together: store first, load right after st_done
        ld_req_valid = 1; ld_req_index = 64'h30;
        st_req_valid = 1; st_req_index = 64'h38; st_wdata = 64'hAB; st_wmask = 64'hFF;
        @(negedge clock);
        check("ls_st_ready", st_req_ready, 1);
        check("ls_ld_wait", ld_req_ready, 0);
        cyc(); st_req_valid = 0;
        cyc();
        mem_resp_valid = 1;
        @(negedge clock);
        check("ls_st_done", st_done, 1);
        check("ls_ld_wait2", ld_req_ready, 0);
        cyc(); mem_resp_valid = 0;
        @(negedge clock); check("ls_ld_ready", ld_req_ready, 1);
        cyc(); ld_req_valid = 0;
        cyc();
        mem_resp_valid = 1; mem_resp_rdata = 64'h77;
        @(negedge clock);
        check("ls_ld_done", ld_done, 1);
        check("ls_ld_rdata", ld_rdata, 64'h77);
        cyc(); mem_resp_valid = 0; mem_resp_rdata = 0;

        // fetch masked by kill in idle, then granted once kill drops
        if_req_valid = 1; if_req_index = 64'h40; if_kill = 1;
        @(negedge clock); check("kill_idle_mask", if_req_ready, 0);
        cyc(); if_kill = 0;
        @(negedge clock); check("kill_idle_grant", if_req_ready, 1);
        cyc(); if_req_valid = 0;
        cyc();
        if_kill = 1;
        @(negedge clock); check("kill_wait_nodone", if_done, 0);
        cyc(); if_kill = 0;
        mem_resp_valid = 1; mem_resp_rdata = 64'h1234;
        @(negedge clock);
        check("kill_resp_nodone", if_done, 0);
        check("kill_resp_rdata", if_rdata, 0);
        cyc(); mem_resp_valid = 0; mem_resp_rdata = 0;
        if_req_valid = 1; if_req_index = 64'h48;
        @(negedge clock); check("kill_next_grant", if_req_ready, 1);
        cyc(); if_req_valid = 0;
        cyc();
        mem_resp_valid = 1; mem_resp_rdata = 64'h5678;
        @(negedge clock);
        check("fetch2_done", if_done, 1);
        check("fetch2_rdata", if_rdata, 64'h5678);
        cyc(); mem_resp_valid = 0; mem_resp_rdata = 0;

        // reset while waiting for a load response; late response is ignored
        ld_req_valid = 1; ld_req_index = 64'h50;
        cyc(); ld_req_valid = 0;
        cyc();
        reset = 1;
        @(negedge clock); check("rstw_no_done", ld_done, 0);
        cyc(); reset = 0;
        mem_resp_valid = 1; mem_resp_rdata = 64'hBEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("rstw_stray_done", ld_done, 0);
            check("rstw_stray_rdata", ld_rdata, 0);
            check("rstw_port_idle", mem_req_valid, 0);
            cyc();
        end
        mem_resp_valid = 0; mem_resp_rdata = 0;
        ld_req_valid = 1; ld_req_index = 64'h58;
        @(negedge clock); check("rstw_regrant", ld_req_ready, 1);
        cyc(); ld_req_valid = 0;
        cyc();
        mem_resp_valid = 1; mem_resp_rdata = 64'h99;
        @(negedge clock);
        check("rstw_ld_done", ld_done, 1);
        check("rstw_ld_rdata", ld_rdata, 64'h99);
        cyc(); mem_resp_valid = 0; mem_resp_rdata = 0;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
